// File: rtl/opc7_link_dma.sv
// -----------------------------------------------------------------------------
// opc7_link_dma
//
// Receive-side DMA for the four osl_rxtx serial links of an opc7 node. Words
// received on the links are drained into the node's 4Kx32 RAM without CPU
// polling. Links are served round-robin. The RAM port is shared with the CPU,
// and the CPU always wins it (ram_gnt low while the CPU uses the RAM).
//
// Ports
//   clk, resetb        node clock, synchronous active-low reset
//   cfg_sel/cfg_wr     CPU register access strobe / write flag (vio bus)
//   cfg_addr, cfg_din  register index and write data
//   cfg_dout           register read data, combinational from cfg_addr
//   link_dor           per-link receive data ready
//   link_dout          link n word on bits [32n+31:32n]
//   link_cs, link_rd   one-hot link select and pop strobe
//   ram_req, ram_gnt   RAM port request / port free this cycle
//   ram_addr, ram_din  RAM write address / data
//   ram_we             RAM write enable (only while ram_gnt)
//   irq                OR over channels of DONE & IE
//
// Register map (n = channel 0..3)
//   4n+0 BASE[11:0]  4n+1 LEN[11:0] (0 = 4096 words)
//   4n+2 COUNT[11:0] read-only
//   4n+3 CTRL: bit0 EN, bit1 DONE (write 1 to clear), bit2 IE
//   16+n STALL[15:0] only when OPC7_LINK_DMA_STATS_EN is defined
//
// Build option
//   OPC7_LINK_DMA_STATS_EN  adds a saturating per-channel stall counter
//                           (cycles spent in WR waiting for ram_gnt).
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | search eligible channels round-robin from rr pointer
// POP   | pop selected link, capture word and target address
// WR    | request RAM port, write held word when granted
// -----------------------------------------------------------------------------
module opc7_link_dma #(
   parameter int NCHAN = 4,
   parameter int AW    = 12
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              cfg_sel,
   input  logic              cfg_wr,
   input  logic [4:0]        cfg_addr,
   input  logic [31:0]       cfg_din,
   output logic [31:0]       cfg_dout,
   input  logic [NCHAN-1:0]  link_dor,
   input  logic [127:0]      link_dout,
   output logic [NCHAN-1:0]  link_cs,
   output logic              link_rd,
   output logic              ram_req,
   input  logic              ram_gnt,
   output logic [AW-1:0]     ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   output logic              irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [AW-1:0]    base_q  [NCHAN];
   logic [AW-1:0]    len_q   [NCHAN];
   logic [AW-1:0]    count_q [NCHAN];
   logic [NCHAN-1:0] en_q;
   logic [NCHAN-1:0] done_q;
   logic [NCHAN-1:0] ie_q;

   logic [1:0]       rr_q;
   logic [1:0]       cur_q;
   logic [31:0]      hold_q;
   logic [AW-1:0]    addr_q;

   logic [NCHAN-1:0] elig;
   logic [1:0]       pick;
   logic             pick_vld;
   logic             wr_fire;
   logic [AW-1:0]    count_inc;

   logic             cfg_we;
   logic [1:0]       cfg_ch;
   logic [1:0]       cfg_reg;
   logic             cfg_chan_hit;

   logic             unused_cfg_din;
   assign unused_cfg_din = ^cfg_din[31:AW];

   assign cfg_we       = cfg_sel & cfg_wr;
   assign cfg_ch       = cfg_addr[3:2];
   assign cfg_reg      = cfg_addr[1:0];
   assign cfg_chan_hit = cfg_we & ~cfg_addr[4];

   assign elig = en_q & ~done_q & link_dor;

   // Walk from the farthest offset down to offset 0 so the channel closest to
   // the rr pointer is the one left in pick.
   always_comb begin
      logic [1:0] idx;
      idx      = '0;
      pick     = rr_q;
      pick_vld = 1'b0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         idx = rr_q + i[1:0];
         if (elig[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pick_vld) state_nxt = S_POP;
         S_POP:   state_nxt = S_WR;
         S_WR:    if (ram_gnt) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Strobes are qualified with resetb so a reset cycle landing in POP or WR
   // can neither pop a link nor write the RAM.
   always_comb begin
      link_cs = '0;
      link_rd = 1'b0;
      ram_req = 1'b0;
      ram_we  = 1'b0;
      if (resetb) begin
         if (state == S_POP) begin
            link_rd        = 1'b1;
            link_cs[cur_q] = 1'b1;
         end
         if (state == S_WR) begin
            ram_req = 1'b1;
            ram_we  = ram_gnt;
         end
      end
   end

   assign wr_fire   = ram_we;
   assign count_inc = count_q[cur_q] + {{(AW-1){1'b0}}, 1'b1};
   assign ram_addr  = addr_q;
   assign ram_din   = hold_q;
   assign irq       = |(done_q & ie_q);

   always_ff @(posedge clk) begin
      if (!resetb) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         cur_q  <= '0;
         rr_q   <= '0;
         hold_q <= '0;
         addr_q <= '0;
      end else begin
         if (state == S_IDLE && pick_vld) cur_q <= pick;
         if (state == S_POP) begin
            hold_q <= link_dout[{cur_q, 5'd0} +: 32];
            addr_q <= base_q[cur_q] + count_q[cur_q];
         end
         if (wr_fire) rr_q <= cur_q + 2'd1;
      end
   end

   // CPU writes are applied first; the DMA completion update comes later in
   // the block so that a DONE set beats a same-cycle W1C, and the in-flight
   // word is always counted.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         for (int n = 0; n < NCHAN; n++) begin
            base_q[n]  <= '0;
            len_q[n]   <= '0;
            count_q[n] <= '0;
         end
         en_q   <= '0;
         done_q <= '0;
         ie_q   <= '0;
      end else begin
         for (int n = 0; n < NCHAN; n++) begin
            if (cfg_chan_hit && cfg_ch == n[1:0]) begin
               case (cfg_reg)
                  2'd0: base_q[n] <= cfg_din[AW-1:0];
                  2'd1: len_q[n]  <= cfg_din[AW-1:0];
                  2'd3: begin
                     en_q[n] <= cfg_din[0];
                     ie_q[n] <= cfg_din[2];
                     if (cfg_din[0] || cfg_din[1]) done_q[n] <= 1'b0;
                     if (cfg_din[0]) count_q[n] <= '0;
                  end
                  default: ;
               endcase
            end
            if (wr_fire && cur_q == n[1:0]) begin
               count_q[n] <= count_inc;
               if (count_inc == len_q[n]) begin
                  done_q[n] <= 1'b1;
                  en_q[n]   <= 1'b0;
               end
            end
         end
      end
   end

`ifdef OPC7_LINK_DMA_STATS_EN
   logic [15:0] stall_q [NCHAN];

   always_ff @(posedge clk) begin
      if (!resetb) begin
         for (int n = 0; n < NCHAN; n++) stall_q[n] <= '0;
      end else begin
         for (int n = 0; n < NCHAN; n++) begin
            if (cfg_we && cfg_addr == {3'b100, n[1:0]})
               stall_q[n] <= '0;
            else if (state == S_WR && !ram_gnt && cur_q == n[1:0] &&
                     stall_q[n] != 16'hFFFF)
               stall_q[n] <= stall_q[n] + 16'd1;
         end
      end
   end
`endif

   always_comb begin
      cfg_dout = '0;
      if (!cfg_addr[4]) begin
         case (cfg_reg)
            2'd0: cfg_dout[AW-1:0] = base_q[cfg_ch];
            2'd1: cfg_dout[AW-1:0] = len_q[cfg_ch];
            2'd2: cfg_dout[AW-1:0] = count_q[cfg_ch];
            default: cfg_dout[2:0] = {ie_q[cfg_ch], done_q[cfg_ch], en_q[cfg_ch]};
         endcase
      end
`ifdef OPC7_LINK_DMA_STATS_EN
      if (cfg_addr[4:2] == 3'b100) cfg_dout[15:0] = stall_q[cfg_addr[1:0]];
`endif
   end

endmodule

// File: tb/tb_opc7_link_dma.sv
// -----------------------------------------------------------------------------
// tb_opc7_link_dma
//
// Bench for opc7_link_dma. Links are modelled as word queues that pop on
// link_rd; the RAM is an array written on ram_we. Directed scenarios cover
// the basic transfer, round-robin order, RAM stall, address wrap, disabling a
// channel mid-transfer and reset mid-transfer. A randomized phase checks every
// RAM write against per-channel expected (address, data) queues built from the
// channel configuration. OPC7_LINK_DMA_STATS_EN selects the stall expectation.
// -----------------------------------------------------------------------------
module tb_opc7_link_dma;

   logic         clk = 1'b0;
   logic         resetb = 1'b0;
   logic         cfg_sel = 1'b0;
   logic         cfg_wr = 1'b0;
   logic [4:0]   cfg_addr = '0;
   logic [31:0]  cfg_din = '0;
   logic [31:0]  cfg_dout;
   logic [3:0]   link_dor = '0;
   logic [127:0] link_dout = '0;
   logic [3:0]   link_cs;
   logic         link_rd;
   logic         ram_req;
   logic         ram_gnt = 1'b1;
   logic [11:0]  ram_addr;
   logic [31:0]  ram_din;
   logic         ram_we;
   logic         irq;

`ifdef OPC7_LINK_DMA_STATS_EN
   localparam logic [31:0] STALL_EXP = 32'd10;
`else
   localparam logic [31:0] STALL_EXP = 32'd0;
`endif

   opc7_link_dma dut (
      .clk       (clk),
      .resetb    (resetb),
      .cfg_sel   (cfg_sel),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_din   (cfg_din),
      .cfg_dout  (cfg_dout),
      .link_dor  (link_dor),
      .link_dout (link_dout),
      .link_cs   (link_cs),
      .link_rd   (link_rd),
      .ram_req   (ram_req),
      .ram_gnt   (ram_gnt),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   logic [3:0]  pop_q = '0;
   logic [3:0]  pop_log [$];
   int          pop_cyc [$];
   logic [31:0] lq [4][$];
   logic [43:0] exp_q [4][$];
   logic [31:0] ram_m [4096];
   bit          sb_on = 1'b0;
   bit          rnd_mode = 1'b0;
   logic [1:0]  sb_ch;
   logic [43:0] sb_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Observe strobes mid-cycle: pops are applied by the link model after the
   // next edge, RAM writes are recorded and scoreboarded here.
   always @(negedge clk) begin
      pop_q = 4'b0;
      if (link_rd) begin
         chk("cs_onehot", 32'($countones(link_cs)), 32'd1);
         pop_q = link_cs;
         pop_log.push_back(link_cs);
         pop_cyc.push_back(cyc);
      end
      if (ram_we) begin
         chk("we_req_gnt", 32'({ram_req, ram_gnt}), 32'd3);
         ram_m[ram_addr] = ram_din;
         wr_cnt++;
         if (sb_on) begin
            sb_ch = ram_addr[11:10];
            if (exp_q[sb_ch].size() == 0) begin
               chk("sb_extra_wr", {20'd0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
               sb_e = exp_q[sb_ch].pop_front();
               chk("sb_addr", {20'd0, ram_addr}, {20'd0, sb_e[43:32]});
               chk("sb_data", ram_din, sb_e[31:0]);
            end
         end
      end
   end

   // Link model: queue front is presented, dor = non-empty (randomly throttled
   // in the random phase), a pop seen in the previous cycle removes the front.
   initial begin
      logic [31:0] tmp;
      forever begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 4; n++) begin
            if (pop_q[n] && lq[n].size() != 0) tmp = lq[n].pop_front();
            link_dor[n] = (lq[n].size() != 0) &&
                          (!rnd_mode || $urandom_range(0, 3) != 0);
            link_dout[32*n +: 32] = (lq[n].size() != 0) ? lq[n][0] : 32'h0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      cfg_sel  = 1'b1;
      cfg_wr   = 1'b1;
      cfg_addr = a;
      cfg_din  = d;
      tick(1);
      cfg_sel  = 1'b0;
      cfg_wr   = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      cfg_addr = a;
      #1;
      d = cfg_dout;
      tick(1);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      cfg_read(a, d);
      chk(tag, d, exp);
   endtask

   task automatic do_reset();
      resetb  = 1'b0;
      ram_gnt = 1'b1;
      cfg_sel = 1'b0;
      cfg_wr  = 1'b0;
      for (int n = 0; n < 4; n++) lq[n].delete();
      tick(2);
      resetb = 1'b1;
      tick(1);
   endtask

   task automatic wait_req(input string tag);
      int k;
      k = 0;
      while (!ram_req && k < 50) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(ram_req), 32'd1);
   endtask

   task automatic wait_wr(input int target, input string tag);
      int k;
      k = 0;
      while (wr_cnt < target && k < 200) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(wr_cnt >= target), 32'd1);
   endtask

   initial begin
      int          w0;
      int          np0;
      int          k;
      int          pend;
      logic [11:0] base_r [4];
      logic [11:0] len_r  [4];
      logic        ie_r   [4];
      logic [31:0] w;
      logic        irq_e;

      // ---------------- reset state ----------------
      do_reset();
      chk("rst_outs", {23'd0, link_cs, link_rd, ram_req, ram_we, irq, 2'b0}, 32'd0);
      chk("rst_addr_din", {20'd0, ram_addr} | ram_din, 32'd0);
      rd_chk("rst_ctrl0", 5'd3, 32'd0);
      cfg_write(5'd20, 32'hFFFF_FFFF);
      rd_chk("unmapped_rd", 5'd20, 32'd0);

      // ---------------- basic transfer on ch0 ----------------
      cfg_write(5'd0, 32'hFFFF_F100);
      rd_chk("base_unused_bits", 5'd0, 32'h100);
      cfg_write(5'd1, 32'd2);
      cfg_write(5'd2, 32'd5);
      rd_chk("count_ro", 5'd2, 32'd0);
      lq[0].push_back(32'hDEAD_BEEF);
      lq[0].push_back(32'h1234_5678);
      w0 = wr_cnt;
      cfg_write(5'd3, 32'h5);
      wait_wr(w0 + 2, "t1_wait");
      chk("t1_irq", 32'(irq), 32'd1);
      chk("t1_ram0", ram_m[12'h100], 32'hDEAD_BEEF);
      chk("t1_ram1", ram_m[12'h101], 32'h1234_5678);
      rd_chk("t1_count", 5'd2, 32'd2);
      rd_chk("t1_ctrl", 5'd3, 32'h6);
      cfg_write(5'd3, 32'h6);
      chk("t1_irq_clr", 32'(irq), 32'd0);
      rd_chk("t1_ctrl_clr", 5'd3, 32'h4);

      // ---------------- round-robin, all links ready ----------------
      do_reset();
      for (int n = 0; n < 4; n++) begin
         cfg_write(5'(4 * n), 32'(12'h200 + 12'(16 * n)));
         cfg_write(5'(4 * n + 3), 32'h1);
      end
      pop_log.delete();
      pop_cyc.delete();
      for (int n = 0; n < 4; n++)
         for (int j = 0; j < 3; j++) lq[n].push_back(32'(n * 256 + j));
      k = 0;
      while (pop_log.size() < 5 && k < 60) begin
         tick(1);
         k++;
      end
      chk("rr_npops", 32'(pop_log.size() >= 5), 32'd1);
      if (pop_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("rr_order", {28'd0, pop_log[i]}, 32'(1 << (i % 4)));
            if (i > 0) chk("rr_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
         end
      end

      // ---------------- RAM stall ----------------
      do_reset();
      ram_gnt = 1'b0;
      cfg_write(5'd0, 32'h300);
      cfg_write(5'd1, 32'd1);
      lq[0].push_back(32'hA5A5_0001);
      cfg_write(5'd3, 32'h1);
      w0 = wr_cnt;
      wait_req("t3_req");
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold", {27'd0, ram_req, ram_we, 3'd0}, 32'h10);
         chk("t3_addr", {20'd0, ram_addr}, 32'h300);
         chk("t3_din", ram_din, 32'hA5A5_0001);
         tick(1);
      end
      ram_gnt = 1'b1;
      #1;
      chk("t3_we_first", 32'(ram_we), 32'd1);
      wait_wr(w0 + 1, "t3_wait");
      chk("t3_ram", ram_m[12'h300], 32'hA5A5_0001);
      rd_chk("t3_ctrl", 5'd3, 32'h2);
      rd_chk("t3_stall", 5'd16, STALL_EXP);
      cfg_write(5'd16, 32'h0);
      rd_chk("t3_stall_clr", 5'd16, 32'd0);

      // ---------------- address wrap on ch2 ----------------
      do_reset();
      cfg_write(5'd8, 32'hFFF);
      cfg_write(5'd9, 32'd3);
      lq[2].push_back(32'h2222_0000);
      lq[2].push_back(32'h2222_0001);
      lq[2].push_back(32'h2222_0002);
      w0 = wr_cnt;
      cfg_write(5'd11, 32'h5);
      wait_wr(w0 + 2, "t4_wait2");
      rd_chk("t4_not_done", 5'd11, 32'h5);
      wait_wr(w0 + 3, "t4_wait3");
      tick(1);
      chk("t4_ram_fff", ram_m[12'hFFF], 32'h2222_0000);
      chk("t4_ram_000", ram_m[12'h000], 32'h2222_0001);
      chk("t4_ram_001", ram_m[12'h001], 32'h2222_0002);
      rd_chk("t4_ctrl", 5'd11, 32'h6);
      rd_chk("t4_count", 5'd10, 32'd3);
      chk("t4_irq", 32'(irq), 32'd1);

      // ---------------- disable ch1 during WR ----------------
      do_reset();
      ram_gnt = 1'b0;
      cfg_write(5'd4, 32'h400);
      cfg_write(5'd5, 32'd5);
      lq[1].push_back(32'h1111_0000);
      lq[1].push_back(32'h1111_0001);
      lq[1].push_back(32'h1111_0002);
      np0 = pop_log.size();
      cfg_write(5'd7, 32'h1);
      wait_req("t5_req");
      cfg_write(5'd7, 32'h0);
      ram_gnt = 1'b1;
      tick(20);
      chk("t5_ram", ram_m[12'h400], 32'h1111_0000);
      chk("t5_npops", 32'(pop_log.size() - np0), 32'd1);
      chk("t5_lq_left", 32'(lq[1].size()), 32'd2);
      chk("t5_dor", 32'(link_dor[1]), 32'd1);
      rd_chk("t5_count", 5'd6, 32'd1);
      rd_chk("t5_ctrl", 5'd7, 32'd0);

      // ---------------- reset while in WR ----------------
      do_reset();
      ram_gnt = 1'b0;
      cfg_write(5'd0, 32'h500);
      cfg_write(5'd1, 32'd2);
      lq[0].push_back(32'h5555_0000);
      lq[0].push_back(32'h5555_0001);
      cfg_write(5'd3, 32'h5);
      wait_req("t6_req");
      w0 = wr_cnt;
      resetb  = 1'b0;
      ram_gnt = 1'b1;
      #1;
      chk("t6_we_in_rst", 32'(ram_we), 32'd0);
      tick(1);
      resetb = 1'b1;
      chk("t6_outs", {23'd0, link_cs, link_rd, ram_req, ram_we, irq, 2'b0}, 32'd0);
      chk("t6_addr_din", {20'd0, ram_addr} | ram_din, 32'd0);
      rd_chk("t6_count", 5'd2, 32'd0);
      rd_chk("t6_ctrl", 5'd3, 32'd0);
      tick(5);
      chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);

      // ---------------- randomized traffic ----------------
      do_reset();
      rnd_mode = 1'b1;
      sb_on    = 1'b1;
      for (int r = 0; r < 3; r++) begin
         ram_gnt = 1'b1;
         for (int n = 0; n < 4; n++) lq[n].delete();
         for (int n = 0; n < 4; n++) begin
            base_r[n] = 12'(n * 12'h400) + 12'($urandom_range(0, 12'h3F0));
            len_r[n]  = 12'($urandom_range(1, 8));
            ie_r[n]   = 1'($urandom_range(0, 1));
            cfg_write(5'(4 * n), {20'd0, base_r[n]});
            cfg_write(5'(4 * n + 1), {20'd0, len_r[n]});
            for (int j = 0; j < int'(len_r[n]) + 2; j++) begin
               w = $urandom;
               lq[n].push_back(w);
               if (j < int'(len_r[n])) exp_q[n].push_back({base_r[n] + 12'(j), w});
            end
            cfg_write(5'(4 * n + 3), {29'd0, ie_r[n], 2'b01});
         end
         k = 0;
         pend = 1;
         while (pend != 0 && k < 3000) begin
            ram_gnt = ($urandom_range(0, 3) != 0);
            tick(1);
            k++;
            pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
         end
         ram_gnt = 1'b1;
         tick(10);
         irq_e = 1'b0;
         for (int n = 0; n < 4; n++) begin
            chk("rnd_drained", 32'(exp_q[n].size()), 32'd0);
            chk("rnd_lq_left", 32'(lq[n].size()), 32'd2);
            rd_chk("rnd_count", 5'(4 * n + 2), {20'd0, len_r[n]});
            rd_chk("rnd_ctrl", 5'(4 * n + 3), {29'd0, ie_r[n], 2'b10});
            irq_e = irq_e | ie_r[n];
         end
         chk("rnd_irq", 32'(irq), 32'(irq_e));
      end
      sb_on    = 1'b0;
      rnd_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/opc7_link_dma.md
Name: opc7_link_dma

Overview:
- Receive-side DMA controller and arbiter for the four osl_rxtx serial links in an opc7 node.
- Drains received words from the links and writes them into the node's 4Kx32 RAM, so the CPU does not poll each link.
- Round-robin arbitration across links. Shares the RAM port with the CPU; the CPU always has priority.
- Configured by the CPU through a small memory-mapped register file on the vio bus.

Parameters:
- NCHAN, 4, number of link channels (fixed at 4 for this node).
- AW, 12, RAM word-address width.

Ports:
- clk  in  1  node clock
- resetb  in  1  reset, synchronous, active-low
- cfg_sel  in  1  CPU register access strobe (vio decode, registered)
- cfg_wr  in  1  1=write, 0=read
- cfg_addr  in  5  register index
- cfg_din  in  32  CPU write data
- cfg_dout  out  32  register read data (combinational from cfg_addr)
- link_dor  in  4  per-link receive data ready
- link_dout  in  128  link n word at bits [32n+31:32n]
- link_cs  out  4  one-hot link select for pop
- link_rd  out  1  pop strobe to the selected link
- ram_req  out  1  DMA requests the RAM port
- ram_gnt  in  1  RAM port free this cycle (CPU not accessing RAM)
- ram_addr  out  12  RAM write address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write enable (only when ram_gnt)
- irq  out  1  OR over channels of (DONE & IE)

Behaviour:
- Register map (n = channel 0..3):
  - 4n+0 BASE[11:0], R/W.
  - 4n+1 LEN[11:0], R/W; LEN=0 means 4096 words.
  - 4n+2 COUNT[11:0], read-only.
  - 4n+3 CTRL, with bit0 EN, bit1 DONE (write-1-to-clear), bit2 IE.
  - Unused bits read 0. Unmapped addresses read 0 and ignore writes.
- Writing CTRL with EN=1 clears COUNT and DONE in the same cycle.
- Reset (resetb=0 at a clk edge):
  - All registers cleared, rr pointer=0, FSM=IDLE.
  - link_cs=0, link_rd=0, ram_req=0, ram_we=0, irq=0.
  - Reset mid-transfer drops any held word.
- A channel is eligible when EN & !DONE & link_dor[n].
- FSM states:
  - IDLE:
    - Search eligible channels round-robin, starting at rr pointer.
    - If any channel is eligible: latch it as cur, go to POP.
    - Otherwise stay in IDLE.
  - POP (1 cycle):
    - link_cs[cur]=1, link_rd=1.
    - Capture link_dout[cur] into a hold register.
    - Latch ram_addr = (BASE + COUNT) mod 4096.
    - Go to WR.
  - WR:
    - ram_req=1.
    - If ram_gnt: ram_we=1 with ram_din=hold, COUNT[cur]++. If the new COUNT == LEN (mod 4096): set DONE, clear EN. Set rr pointer = cur+1 mod 4. Go to IDLE.
    - If !ram_gnt: hold all outputs and wait (no timeout).
- Latency: minimum 3 cycles from a link_dor edge seen in IDLE to ram_we. Sustained rate is 1 word per 3 cycles when ram_gnt=1.
- Boundary conditions:
  - CPU write to CTRL.EN=0 while cur is in POP/WR: the in-flight word still completes and counts. No further words are taken on that channel.
  - CPU writes to BASE/LEN during WR do not affect the latched ram_addr.
  - Simultaneous DONE set and a CPU W1C write in the same cycle: set wins.
  - COUNT wraps mod 4096. ram_addr wraps mod 4096 (BASE+COUNT overflow discarded).
- link_rd is never asserted without exactly one link_cs bit set.

Optional Feature:
- Macro: OPC7_LINK_DMA_STATS_EN.
- With the macro defined:
  - Adds a 16-bit saturating stall counter per channel, readable at address 16+n.
  - The counter increments each cycle the FSM is in WR for that channel with ram_gnt=0.
  - Any write to address 16+n clears it.
- Without the macro: addresses 16..19 read 0, writes are ignored, and no counter logic is generated.

Test Plan:
- Ch0 BASE=0x100, LEN=2, EN=1, IE=1; link0 presents 0xDEADBEEF then 0x12345678 with ram_gnt=1 -> RAM[0x100]=0xDEADBEEF, RAM[0x101]=0x12345678, COUNT=2, DONE=1, EN=0, irq=1; W1C to DONE -> irq=0.
- All four channels enabled, all link_dor=1 continuously -> service order 0,1,2,3,0; link_cs one-hot, one pop per 3 cycles.
- ram_gnt held 0 for 10 cycles during WR -> ram_req=1, ram_we=0, data and address stable; write lands on the first cycle ram_gnt=1. With STATS_EN, addr 16 reads 10.
- Ch2 BASE=0xFFF, LEN=3 -> writes land at 0xFFF, 0x000, 0x001; DONE set after the third write.
- Disable ch1 during WR -> the held word is still written and COUNT increments; link1 is not popped again despite link_dor[1]=1.
- Assert resetb=0 for one cycle while in WR -> next cycle all outputs 0, COUNT=0, no RAM write.
